// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift controller: applies the 16/8/4/2/1 stages one per
// cycle through a single stage datapath, with a start/busy/done handshake.
module shift_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [4:0]       shamt,
  input  logic             dir,
  input  logic             arith,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef struct packed {
    logic [4:0] shamt;
    logic       dir;
    logic       arith;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       k_q, k_d;

  logic [4:0]       amt_w, low_mask_w;
  logic [WIDTH-1:0] shifted_w, stage_w;
  logic             last_w;

  // Shared stage: shift by 2^k, applied only when shamt bit k is set.
  assign amt_w      = 5'(1) << k_q;
  assign low_mask_w = amt_w - 5'd1;
  assign last_w     = (k_q == 3'd0) ||
                      (EARLY_EXIT && ((op_q.shamt & low_mask_w) == 5'd0));

  always_comb begin
    shifted_w = work_q;
    if (!op_q.dir)
      shifted_w = work_q << amt_w;
    else if (op_q.arith)
      shifted_w = $signed(work_q) >>> amt_w;
    else
      shifted_w = work_q >> amt_w;
    stage_w = op_q.shamt[k_q] ? shifted_w : work_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    k_d      = k_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d   = '{shamt: shamt, dir: dir, arith: arith};
          work_d = a;
          k_d    = 3'd4;
          if (EARLY_EXIT && shamt == 5'd0) begin
            result_d = a;
            state_d  = DONE;
          end else begin
            state_d  = SHIFT;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_w;
        if (last_w) begin
          result_d = stage_w;
          state_d  = DONE;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      result_q <= '0;
      k_q      <= 3'd4;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      k_q      <= k_d;
    end
  end

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed + random bench for shift_sequencer; instance 0 runs EARLY_EXIT=0,
// instance 1 runs EARLY_EXIT=1. Expected results are queued at accept time.
module tb_shift_sequencer;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy;
  } exp_t;

  logic        clk;
  logic        rst_n  [2];
  logic        start  [2];
  logic [31:0] a      [2];
  logic [4:0]  shamt  [2];
  logic        dir    [2];
  logic        arith  [2];
  logic        ready  [2];
  logic        busy   [2];
  logic        done   [2];
  logic [31:0] result [2];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  shift_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .a(a[0]), .shamt(shamt[0]),
    .dir(dir[0]), .arith(arith[0]), .ready(ready[0]), .busy(busy[0]),
    .done(done[0]), .result(result[0]));

  shift_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .a(a[1]), .shamt(shamt[1]),
    .dir(dir[1]), .arith(arith[1]), .ready(ready[1]), .busy(busy[1]),
    .done(done[1]), .result(result[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(logic [31:0] v, logic [4:0] s,
                                            logic d, logic ar);
    logic [31:0] r;
    if (!d)      r = v << s;
    else if (ar) r = $signed(v) >>> s;
    else         r = v >> s;
    return r;
  endfunction

  function automatic int lat_of(int e, logic [4:0] s);
    if (e == 0) return 5;
    if (s == 5'd0) return 0;
    for (int b = 0; b < 5; b++)
      if (s[b]) return 1 + (4 - b);
    return 5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(int e, exp_t x);
    if (e == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic pop_exp(int e, output exp_t x, output bit ok);
    ok = 1'b0;
    if (e == 0 && q0.size() > 0) begin x = q0.pop_front(); ok = 1'b1; end
    if (e == 1 && q1.size() > 0) begin x = q1.pop_front(); ok = 1'b1; end
  endtask

  task automatic drive(int e, logic [31:0] av, logic [4:0] s, logic d, logic ar);
    @(negedge clk);
    a[e] = av; shamt[e] = s; dir[e] = d; arith[e] = ar; start[e] = 1'b1;
  endtask

  // Waits (bounded) for a done pulse, counting SHIFT cycles seen on the way.
  task automatic wait_done(int e, string tag);
    int   n = 0;
    int   b = 0;
    bit   got = 1'b0;
    bit   ok;
    exp_t x;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (done[e]) got = 1'b1;
      else if (busy[e]) b++;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      pop_exp(e, x, ok);
      chk({tag, "_sb_nonempty"}, 32'(ok), 32'd1);
      if (ok) begin
        chk({tag, "_result"}, result[e], x.res);
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(x.cyc));
        chk({tag, "_busy_cycles"}, 32'(b), 32'(x.busy));
        chk({tag, "_ready_in_done"}, 32'(ready[e]), 32'd1);
      end
    end
  endtask

  task automatic run_op(int e, string tag, logic [31:0] av, logic [4:0] s,
                        logic d, logic ar);
    int   t;
    int   l;
    exp_t x;
    drive(e, av, s, d, ar);
    @(posedge clk);
    #1;
    t = cyc;
    start[e] = 1'b0;
    a[e] = ~av;
    l = lat_of(e, s);
    x.res = ref_shift(av, s, d, ar); x.cyc = t + l; x.busy = l;
    push_exp(e, x);
    wait_done(e, tag);
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(ready[e]), 32'd1);
    chk({tag, "_idle_done"}, 32'(done[e]), 32'd0);
    chk({tag, "_idle_hold"}, result[e], x.res);
  endtask

  initial begin
    int   t;
    int   ndone;
    exp_t x;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic        rd, rr;

    for (int e = 0; e < 2; e++) begin
      rst_n[e] = 1'b0; start[e] = 1'b0; a[e] = '0; shamt[e] = '0;
      dir[e] = 1'b0; arith[e] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      chk("rst_ready", 32'(ready[e]), 32'd1);
      chk("rst_busy", 32'(busy[e]), 32'd0);
      chk("rst_done", 32'(done[e]), 32'd0);
      chk("rst_result", result[e], 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    run_op(0, "e0_sll4",      32'h0000_00F1, 5'd4,  1'b0, 1'b0);
    run_op(0, "e0_sra31",     32'h8000_0010, 5'd31, 1'b1, 1'b1);
    run_op(0, "e0_srl31",     32'h8000_0010, 5'd31, 1'b1, 1'b0);
    run_op(0, "e0_sra16",     32'hDEAD_BEEF, 5'd16, 1'b1, 1'b1);
    run_op(0, "e0_sh0",       32'h1234_5678, 5'd0,  1'b0, 1'b0);
    run_op(1, "e1_sra16",     32'hDEAD_BEEF, 5'd16, 1'b1, 1'b1);
    run_op(1, "e1_sh0",       32'h1234_5678, 5'd0,  1'b1, 1'b1);
    run_op(1, "e1_sll4",      32'h0000_00F1, 5'd4,  1'b0, 1'b0);
    run_op(1, "e1_sra31",     32'h8000_0010, 5'd31, 1'b1, 1'b1);
    run_op(1, "e1_srl1",      32'hF000_0001, 5'd1,  1'b1, 1'b0);

    // Back-to-back with start held: second op is accepted in the DONE cycle.
    drive(0, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    t = cyc;
    x.res = 32'h0000_0002; x.cyc = t + 5;  x.busy = 5; push_exp(0, x);
    // One SHIFT cycle of the second op passes before its wait starts.
    x.res = 32'hF000_0000; x.cyc = t + 11; x.busy = 4; push_exp(0, x);
    a[0] = 32'h8000_0000; shamt[0] = 5'd3; dir[0] = 1'b1; arith[0] = 1'b1;
    wait_done(0, "b2b_first");
    @(posedge clk);
    #1;
    a[0] = 32'h1234_5678; dir[0] = 1'b0; shamt[0] = 5'd7;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, "b2b_second");

    // Asynchronous reset in the middle of SHIFT.
    drive(0, 32'hAAAA_5555, 5'd5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready[0]), 32'd1);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_done", 32'(done[0]), 32'd0);
    chk("midrst_result", result[0], 32'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    rst_n[0] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    run_op(0, "post_rst_sll8", 32'h0000_FFFF, 5'd8, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      for (int e = 0; e < 2; e++) begin
        ra = $urandom;
        rs = 5'($urandom_range(0, 31));
        rd = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
        run_op(e, "rand", ra, rs, rd, rr);
      end
    end

    chk("sb_empty0", 32'(q0.size()), 32'd0);
    chk("sb_empty1", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
